mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max BUSY cycles waiting for mem_ack (range 1..255).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port exm_sig, input, 5, EX/MEM control: [4] regWrite, [3] memToReg, [2] memRead, [1] memWrite, [0] branch.
REQ-005 SHALL have port exm_zero, input, 1, ALU zero flag.
REQ-006 SHALL have port exm_alu, input, 32, ALU result / memory byte address.
REQ-007 SHALL have port exm_wdata, input, 32, store data.
REQ-008 SHALL have port exm_rd, input, 5, destination register.
REQ-009 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, 32), mem_wdata (output, 32): data-memory request.
REQ-010 SHALL have ports mem_rdata (input, 32) and mem_ack (input, 1): data-memory response.
REQ-011 SHALL have port stall, output, 1, freeze PC, IF/ID, ID/EX, EX/MEM.
REQ-012 SHALL have port pc_src, output, 1, branch taken.
REQ-013 SHALL have ports mwb_sig (output, 2: [1] regWrite, [0] memToReg), mwb_rdata (output, 32), mwb_alu (output, 32), mwb_rd (output, 5): MEM/WB register.
REQ-014 SHALL have port mem_err, output, 1, one-cycle pulse on misaligned or timed-out access.

Function
REQ-015 SHALL drive pc_src = exm_sig[0] & exm_zero combinationally, never gated by stall.
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE; access = exm_sig[2] | exm_sig[1]; aligned = (exm_alu[1:0] == 0).
REQ-017 IDLE, no access: stall=0; MEM/WB loads {exm_sig[4:3], 0, exm_alu, exm_rd} at clock edge; state stays IDLE (latency 1).
REQ-018 IDLE, access and aligned: stall=1 combinationally; at edge go BUSY, register mem_req=1, mem_we=exm_sig[1], mem_addr=exm_alu, mem_wdata=exm_wdata, timeout counter=0.
REQ-019 IDLE, access and misaligned: no request; stall=0; MEM/WB loads with regWrite forced 0; mem_err=1 next cycle for one cycle.
REQ-020 memRead and memWrite both set SHALL be treated as write (mem_we=1), memToReg data 0.
REQ-021 BUSY: stall=1; mem_req, mem_we, mem_addr, mem_wdata held stable until ack or timeout.
REQ-022 BUSY, mem_ack=1: capture mem_rdata (reads; 0 for writes), drop mem_req at edge, go DONE.
REQ-023 BUSY, no ack: counter increments; when counter reaches TIMEOUT-1 without ack, drop mem_req, captured data=0, flag error, go DONE.
REQ-024 mem_ack outside BUSY SHALL be ignored.
REQ-025 While stall=1, MEM/WB SHALL load a bubble (mwb_sig=0, mwb_rd=0, data 0) each edge.
REQ-026 DONE: stall=0; MEM/WB loads {exm_sig[4:3], captured data, exm_alu, exm_rd}, regWrite forced 0 if timed out; mem_err=1 next cycle if timed out; go IDLE; no new request issued in DONE.
REQ-027 Access latency SHALL be 1 (IDLE) + N (BUSY, ack on Nth cycle) + 1 (DONE) cycles; at most TIMEOUT+2.
REQ-028 mem_addr, mem_wdata SHALL hold last value outside BUSY; mem_we=0 outside BUSY.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mwb_sig=0, mwb_rdata=0, mwb_alu=0, mwb_rd=0, mem_err=0, counter=0; stall then follows REQ-017..019 for current inputs.
REQ-030 rst asserted in BUSY SHALL abort the request (mem_req low in same cycle), discard any ack, and emit no mem_err.

Verification
REQ-031 ALU op exm_sig=10000, exm_alu=0x1234, exm_rd=7 -> no stall; next cycle mwb_sig=10, mwb_alu=0x1234, mwb_rd=7, mem_req=0.
REQ-032 Load exm_sig=11100, addr 0x40, ack on 3rd BUSY cycle with rdata 0xDEADBEEF -> stall high 4 cycles, mem_req high 3 cycles, MEM/WB then shows 0xDEADBEEF, rd, sig=11; one bubble per stalled edge.
REQ-033 Store exm_sig=00010, addr 0x44, data 0xCAFEF00D, ack 1st BUSY cycle -> mem_we=1, mem_wdata=0xCAFEF00D, stall 2 cycles, mwb_sig=00.
REQ-034 Load addr 0x42 -> no mem_req, no stall, mem_err pulse 1 cycle, mwb_sig[1]=0.
REQ-035 Load with mem_ack never asserted, TIMEOUT=15 -> mem_req high exactly 15 cycles, then DONE, mem_err pulse, mwb_rdata=0, regWrite=0, stall released.
REQ-036 Branch exm_sig=00001, exm_zero=1 -> pc_src=1 same cycle; rst pulse during BUSY -> mem_req low immediately, IDLE, MEM/WB zero, no mem_err.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage; handshakes data memory (req/ack, timeout), stalls pipeline, loads MEM/WB, resolves branch
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  exm_sig,
  input  logic        exm_zero,
  input  logic [31:0] exm_alu,
  input  logic [31:0] exm_wdata,
  input  logic [4:0]  exm_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        pc_src,
  output logic [1:0]  mwb_sig,
  output logic [31:0] mwb_rdata,
  output logic [31:0] mwb_alu,
  output logic [4:0]  mwb_rd,
  output logic        mem_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
  state_t state, state_n;
  logic [7:0] cnt;
  logic [31:0] cap;
  logic tout, access, aligned, issue, expire, kill;
  assign pc_src = exm_sig[0] & exm_zero;
  assign access = |exm_sig[2:1];
  assign aligned = exm_alu[1:0] == 2'b00;
  assign issue = state == IDLE && access && aligned;
  assign expire = state == BUSY && !mem_ack && cnt == TLIM;
  assign kill = state == IDLE ? access && !aligned : state == DONE && tout;
  always_comb begin
    state_n = state == IDLE ? (issue ? BUSY : IDLE)
            : state == BUSY ? (mem_ack || expire ? DONE : BUSY)
            : IDLE;
    stall = issue || state == BUSY;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cnt <= '0;
      cap <= '0;
      tout <= 1'b0;
      mwb_sig <= '0;
      mwb_rdata <= '0;
      mwb_alu <= '0;
      mwb_rd <= '0;
      mem_err <= 1'b0;
    end else begin
      mem_err <= kill;
      if (issue) begin
        mem_req <= 1'b1;
        mem_we <= exm_sig[1];
        mem_addr <= exm_alu;
        mem_wdata <= exm_wdata;
        cnt <= '0;
      end
      if (state == BUSY) begin
        if (mem_ack || expire) begin
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          cap <= mem_ack && !mem_we ? mem_rdata : '0;
          tout <= !mem_ack;
        end else cnt <= cnt + 8'd1;
      end
      mwb_sig <= stall ? 2'b00 : {exm_sig[4] & ~kill, exm_sig[3]};
      mwb_rdata <= !stall && state == DONE ? cap : '0;
      mwb_alu <= stall ? '0 : exm_alu;
      mwb_rd <= stall ? '0 : exm_rd;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized transaction-level check of mem_access_unit against a spec-rule model
module tb_mem_access_unit;
  localparam int TO = 15;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] exm_sig = '0, exm_rd = '0;
  logic exm_zero = 1'b0;
  logic [31:0] exm_alu = '0, exm_wdata = '0, mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic mem_req, mem_we, stall, pc_src, mem_err;
  logic [31:0] mem_addr, mem_wdata, mwb_rdata, mwb_alu;
  logic [1:0] mwb_sig;
  logic [4:0] mwb_rd;
  int errors = 0, checks = 0;
  logic [31:0] exp_addr = '0, exp_wd = '0;
  always #5 clk = ~clk;
  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .exm_sig(exm_sig), .exm_zero(exm_zero), .exm_alu(exm_alu),
    .exm_wdata(exm_wdata), .exm_rd(exm_rd), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .pc_src(pc_src), .mwb_sig(mwb_sig), .mwb_rdata(mwb_rdata),
    .mwb_alu(mwb_alu), .mwb_rd(mwb_rd), .mem_err(mem_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [4:0] sig, input logic zero, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [31:0] rdv, input logic [4:0] rd,
                        input int delay);
    bit acc, algn, timed;
    int n, st, rq, guard;
    bit bub, held;
    logic [1:0] e_sig;
    logic [31:0] e_data;
    bit e_err;
    acc = sig[2] | sig[1];
    algn = alu[1:0] == 2'b00;
    timed = delay < 1 || delay > TO;
    n = timed ? TO : delay;
    if (!acc) begin
      e_sig = sig[4:3]; e_data = 0; e_err = 0; n = -1;
    end else if (!algn) begin
      e_sig = {1'b0, sig[3]}; e_data = 0; e_err = 1; n = -1;
    end else begin
      e_sig = {sig[4] & !timed, sig[3]};
      e_data = (timed || sig[1]) ? 0 : rdv;
      e_err = timed;
      exp_addr = alu; exp_wd = wd;
    end
    exm_sig = sig; exm_zero = zero; exm_alu = alu; exm_wdata = wd; exm_rd = rd; mem_rdata = rdv;
    #1;
    chk("pc_src", 32'(pc_src), 32'(sig[0] & zero));
    st = 0; rq = 0; bub = 1; held = 1; guard = 0;
    while (stall && guard < 300) begin
      st++; guard++;
      if (mem_req) begin
        rq++;
        if (mem_addr !== alu || mem_wdata !== wd || mem_we !== sig[1]) held = 0;
      end
      if (pc_src !== (sig[0] & zero)) held = 0;
      mem_ack = mem_req ? (rq == delay) : 1'($urandom % 2);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mwb_sig !== 0 || mwb_rd !== 0 || mwb_rdata !== 0 || mwb_alu !== 0 || mem_err !== 0) bub = 0;
    end
    chk("stall_cycles", st, n + 1);
    chk("req_cycles", rq, n < 0 ? 0 : n);
    chk("req_held", 32'(held), 1);
    chk("bubbles", 32'(bub), 1);
    chk("req_released", 32'(mem_req), 0);
    mem_ack = 1'($urandom % 2);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("mwb_sig", 32'(mwb_sig), 32'(e_sig));
    chk("mwb_rdata", mwb_rdata, e_data);
    chk("mwb_alu", mwb_alu, alu);
    chk("mwb_rd", 32'(mwb_rd), 32'(rd));
    chk("mem_err", 32'(mem_err), 32'(e_err));
    chk("mem_we_idle", 32'(mem_we), 0);
    chk("mem_addr_hold", mem_addr, exp_addr);
    chk("mem_wdata_hold", mem_wdata, exp_wd);
  endtask
  initial begin
    #3;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_mwb_sig", 32'(mwb_sig), 0);
    chk("rst_mwb_alu", mwb_alu, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_err", 32'(mem_err), 0);
    chk("rst_stall", 32'(stall), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(5'b10000, 1'b0, 32'h1234, 32'h0, 32'h0, 5'd7, 0);
    run_op(5'b11100, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 5'd9, 3);
    run_op(5'b00010, 1'b0, 32'h44, 32'hCAFEF00D, 32'h5555AAAA, 5'd0, 1);
    run_op(5'b11100, 1'b0, 32'h42, 32'h0, 32'h0, 5'd3, 1);
    run_op(5'b10000, 1'b0, 32'h8, 32'h0, 32'h0, 5'd4, 0);
    run_op(5'b11100, 1'b0, 32'h48, 32'h0, 32'h12345678, 5'd5, 0);
    run_op(5'b11110, 1'b0, 32'h4C, 32'h77, 32'h99999999, 5'd6, 2);
    run_op(5'b11100, 1'b0, 32'h50, 32'h0, 32'hABCDEF01, 5'd8, TO);
    run_op(5'b00001, 1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    exm_sig = 5'b11100; exm_alu = 32'h80; exm_rd = 5'd2; exm_zero = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(mem_req), 1);
    mem_ack = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_busy_req", 32'(mem_req), 0);
    chk("rst_busy_mwb", 32'(mwb_sig), 0);
    chk("rst_busy_addr", mem_addr, 0);
    chk("rst_busy_err", 32'(mem_err), 0);
    exp_addr = 0; exp_wd = 0;
    exm_sig = 5'b10000; exm_alu = 32'h99; exm_rd = 5'd1;
    #1;
    rst = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_err", 32'(mem_err), 0);
    chk("post_rst_req", 32'(mem_req), 0);
    chk("post_rst_sig", 32'(mwb_sig), 2'b10);
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom % 4 != 0) a[1:0] = 2'b00;
      run_op(5'($urandom), 1'($urandom), a, $urandom, $urandom, 5'($urandom),
             int'($urandom_range(0, TO + 2)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
